// File: rtl/count_enable_debouncer_if.sv
// Button-conditioning bus: raw button and mode in, clean enable and debounce status out.
interface count_enable_debouncer_if;
    logic       btn_in;
    logic [1:0] mode;
    logic       en_out;
    logic       db_level;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] press_count;

    modport master (
        output btn_in, mode,
        input  en_out, db_level, press_pulse, release_pulse, press_count
    );

    modport slave (
        input  btn_in, mode,
        output en_out, db_level, press_pulse, release_pulse, press_count
    );
endinterface

// File: rtl/count_enable_debouncer.sv
// Synchronises and debounces a raw button, producing a count enable selected by mode
// (level, single pulse or toggle) plus a wrapping press counter.
module count_enable_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input logic                      clk,
    input logic                      rst,
    count_enable_debouncer_if.slave  bus
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} state_e;

    state_e           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db_level;
    logic             r_press_pulse;
    logic             r_release_pulse;
    logic             r_toggle;
    logic [7:0]       r_press_count;
    logic             w_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= StIdle;
            r_sync1         <= 1'b0;
            r_sync2         <= 1'b0;
            r_cnt           <= '0;
            r_db_level      <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_toggle        <= 1'b0;
            r_press_count   <= 8'd0;
        end else begin
            r_sync1         <= bus.btn_in;
            r_sync2         <= r_sync1;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (r_sync2) begin
                        r_state <= StPressWait;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                StPressWait: begin
                    if (!r_sync2) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end else if (r_cnt == LP_LAST) begin
                        r_state       <= StHeld;
                        r_cnt         <= '0;
                        r_db_level    <= 1'b1;
                        r_press_pulse <= 1'b1;
                        r_press_count <= r_press_count + 8'd1;
                        r_toggle      <= ~r_toggle;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StHeld: begin
                    if (!r_sync2) begin
                        r_state <= StReleaseWait;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                StReleaseWait: begin
                    if (r_sync2) begin
                        r_state <= StHeld;
                        r_cnt   <= '0;
                    end else if (r_cnt == LP_LAST) begin
                        r_state         <= StIdle;
                        r_cnt           <= '0;
                        r_db_level      <= 1'b0;
                        r_release_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Mode is deliberately unregistered so a mode change retargets en_out in the same cycle.
    always_comb begin
        w_en = r_db_level;
        case (bus.mode)
            2'b01:   w_en = r_press_pulse;
            2'b10:   w_en = r_toggle;
            default: w_en = r_db_level;
        endcase
    end

    assign bus.en_out        = w_en;
    assign bus.db_level      = r_db_level;
    assign bus.press_pulse   = r_press_pulse;
    assign bus.release_pulse = r_release_pulse;
    assign bus.press_count   = r_press_count;

endmodule
